// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB master sequencer (IDLE/SETUP/ACCESS) fed by the bridge FIFO pair
// Optional slave-error capture enabled by defining APB_SLVERR_EN.
module apb_master_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              transfer,
    input  logic [ADDR_W:0]   addr_temp,
    input  logic [DATA_W-1:0] data_temp,
    input  logic              Pready,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pslverr,
    output logic              Psel,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pint,
    output logic [DATA_W-1:0] Prdata_temp,
    output logic              rd_valid,
    output logic              Perr,
    output logic [15:0]       xfer_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] prdata_temp_q, prdata_temp_d;
    logic              rd_valid_q, rd_valid_d;
    logic              perr_q, perr_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        prdata_temp_d = prdata_temp_q;
        rd_valid_d    = 1'b0;
        perr_d        = perr_q;
        xfer_cnt_d    = xfer_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d  = ST_SETUP;
                    paddr_d  = addr_temp[ADDR_W-1:0];
                    pwrite_d = addr_temp[ADDR_W];
                    pwdata_d = data_temp;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Completion always passes through IDLE so the FIFO head can advance.
                if (Pready) begin
                    state_d    = ST_IDLE;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                    if (!pwrite_q) begin
                        prdata_temp_d = Prdata;
                        rd_valid_d    = 1'b1;
                    end
`ifdef APB_SLVERR_EN
                    perr_d = perr_q | Pslverr;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifndef APB_SLVERR_EN
        perr_d = 1'b0;
`endif

        // Psel/Penable are registered, so they follow the next state.
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

`ifndef APB_SLVERR_EN
    logic unused_slverr;
    assign unused_slverr = Pslverr;
`endif

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            prdata_temp_q <= '0;
            rd_valid_q    <= 1'b0;
            perr_q        <= 1'b0;
            xfer_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            prdata_temp_q <= prdata_temp_d;
            rd_valid_q    <= rd_valid_d;
            perr_q        <= perr_d;
            xfer_cnt_q    <= xfer_cnt_d;
        end
    end

    assign Pint        = (state_q == ST_ACCESS);
    assign Psel        = psel_q;
    assign Penable     = penable_q;
    assign Pwrite      = pwrite_q;
    assign Paddr       = paddr_q;
    assign Pwdata      = pwdata_q;
    assign Prdata_temp = prdata_temp_q;
    assign rd_valid    = rd_valid_q;
    assign Perr        = perr_q;
    assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - self-checking bench for apb_master_fsm
module tb_apb_master_fsm;

    logic        Pclk = 1'b0;
    logic        Preset = 1'b1;
    logic        transfer = 1'b0;
    logic [32:0] addr_temp = '0;
    logic [31:0] data_temp = '0;
    logic        Pready = 1'b0;
    logic [31:0] Prdata = '0;
    logic        Pslverr = 1'b0;
    logic        Psel, Penable, Pwrite, Pint, rd_valid, Perr;
    logic [31:0] Paddr, Pwdata, Prdata_temp;
    logic [15:0] xfer_cnt;

    apb_master_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
        .Pclk(Pclk), .Preset(Preset), .transfer(transfer), .addr_temp(addr_temp),
        .data_temp(data_temp), .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr),
        .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pint(Pint), .Prdata_temp(Prdata_temp), .rd_valid(rd_valid), .Perr(Perr),
        .xfer_cnt(xfer_cnt)
    );

    always #5 Pclk = ~Pclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pops = 0;

    always @(posedge Pclk) begin
        cyc <= cyc + 1;
        if (transfer && Pready && Pint && !Preset) pops <= pops + 1;
    end

    // Transaction-level reference state
    logic [15:0] m_cnt = 16'd0;
    logic [31:0] m_rdata = '0;
    logic        m_perr = 1'b0;
    int          m_pops = 0;
    int          last_setup_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        transfer = 1'b0;
        repeat (n) @(negedge Pclk);
        chk("idle_psel", {63'd0, Psel}, 64'd0);
        chk("idle_rdv", {63'd0, rd_valid}, 64'd0);
    endtask

    // Called at a negedge while the FSM is idle; returns at the negedge of the first IDLE cycle after completion.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input logic drop_mid);
        chk("pre_psel", {63'd0, Psel}, 64'd0);
        chk("pre_pint", {63'd0, Pint}, 64'd0);
        transfer  = 1'b1;
        addr_temp = {wr, addr};
        data_temp = data;
        Pready    = 1'b0;
        @(negedge Pclk);
        last_setup_cyc = cyc;
        chk("setup_ctl", {61'd0, Psel, Penable, Pint}, 64'b100);
        chk("setup_addr", {32'd0, Paddr}, {32'd0, addr});
        chk("setup_wr", {63'd0, Pwrite}, {63'd0, wr});
        chk("setup_wdata", {32'd0, Pwdata}, {32'd0, data});
        if (drop_mid) begin
            transfer  = 1'b0;
            addr_temp = {~wr, ~addr};
            data_temp = ~data;
        end
        for (int w = 0; w <= waits; w++) begin
            @(negedge Pclk);
            chk("access_ctl", {61'd0, Psel, Penable, Pint}, 64'b111);
            chk("access_addr", {32'd0, Paddr}, {32'd0, addr});
            chk("access_wdata", {32'd0, Pwdata}, {32'd0, data});
            Pready  = (w == waits);
            Prdata  = (w == waits) ? rdata : ~rdata;
            Pslverr = (w == waits) ? slverr : 1'b1;
        end
        m_cnt = m_cnt + 16'd1;
        if (!wr) m_rdata = rdata;
`ifdef APB_SLVERR_EN
        m_perr = m_perr | slverr;
`endif
        if (transfer) m_pops++;
        @(negedge Pclk);
        Pready  = 1'b0;
        Pslverr = 1'b0;
        chk("done_ctl", {61'd0, Psel, Penable, Pint}, 64'd0);
        chk("done_rdv", {63'd0, rd_valid}, {63'd0, ~wr});
        chk("done_rdata", {32'd0, Prdata_temp}, {32'd0, m_rdata});
        chk("done_cnt", {48'd0, xfer_cnt}, {48'd0, m_cnt});
        chk("done_perr", {63'd0, Perr}, {63'd0, m_perr});
        chk("done_pops", pops, m_pops);
    endtask

    int c1;

    initial begin
        repeat (2) @(negedge Pclk);
        chk("rst_ctl", {58'd0, Psel, Penable, Pwrite, Pint, rd_valid, Perr}, 64'd0);
        chk("rst_bus", {Paddr, Pwdata}, 64'd0);
        chk("rst_misc", {16'd0, Prdata_temp, xfer_cnt}, 64'd0);
        Preset = 1'b0;
        @(negedge Pclk);

        do_xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0);
        idle_cycles(1);
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
        idle_cycles(1);

        // Back-to-back: second entry presented in the single IDLE cycle
        do_xfer(1'b1, 32'h0000_0100, 32'hAAAA_0001, 0, 32'h0, 1'b0, 1'b0);
        c1 = last_setup_cyc;
        do_xfer(1'b0, 32'h0000_0104, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("b2b_spacing", last_setup_cyc - c1, 64'd3);
        idle_cycles(1);

        // Reset in ACCESS: no pop, entry reissued afterwards
        transfer  = 1'b1;
        addr_temp = {1'b1, 32'h0000_0200};
        data_temp = 32'h5555_AAAA;
        Pready    = 1'b0;
        repeat (2) @(negedge Pclk);
        chk("pre_rst_pint", {63'd0, Pint}, 64'd1);
        Preset = 1'b1;
        @(negedge Pclk);
        chk("midrst_ctl", {58'd0, Psel, Penable, Pwrite, Pint, rd_valid, Perr}, 64'd0);
        chk("midrst_bus", {Paddr, Pwdata}, 64'd0);
        chk("midrst_misc", {16'd0, Prdata_temp, xfer_cnt}, 64'd0);
        chk("midrst_pops", pops, m_pops);
        m_cnt = 16'd0; m_rdata = '0; m_perr = 1'b0;
        Preset = 1'b0;
        do_xfer(1'b1, 32'h0000_0200, 32'h5555_AAAA, 1, 32'h0, 1'b0, 1'b0);
        idle_cycles(1);

        // Slave error then a clean transfer
        do_xfer(1'b1, 32'h0000_0300, 32'h0BAD_0BAD, 0, 32'h0, 1'b1, 1'b0);
        idle_cycles(1);
        do_xfer(1'b0, 32'h0000_0304, 32'h0, 2, 32'h7777_8888, 1'b0, 1'b0);
        idle_cycles(2);

        // Counter wrap
        force dut.xfer_cnt_q = 16'hFFFF;
        @(negedge Pclk);
        release dut.xfer_cnt_q;
        m_cnt = 16'hFFFF;
        chk("cnt_preload", {48'd0, xfer_cnt}, 64'hFFFF);
        do_xfer(1'b1, 32'h0000_0400, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b0);
        chk("cnt_wrap", {48'd0, xfer_cnt}, 64'd0);
        idle_cycles(1);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3),
                    $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
